// File: rtl/fetch_realign_buffer_pkg.sv
// Shared definitions for the fetch realign buffer: RVC length decode,
// cache byte-order normalisation and the request state encoding.
package fetch_realign_buffer_pkg;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam logic [1:0]  RVC_MASK = 2'b11;

    typedef enum logic {
        REQ_IDLE,
        REQ_PEND
    } req_state_e;

    // A halfword whose low two bits are 2'b11 opens a 32-bit instruction.
    function automatic logic is_full_width(input logic [15:0] half);
        return half[1:0] == RVC_MASK;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] word);
        return {word[7:0], word[15:8], word[23:16], word[31:24]};
    endfunction

endpackage

// File: rtl/fetch_realign_buffer_if.sv
// IF-stage and instruction-cache signals of the fetch realign buffer.
// master is the buffer itself; slave is the IF stage plus cache side.
interface fetch_realign_buffer_if;

    logic [31:0] pc;
    logic        invalidate;
    logic        ready;
    logic        compressed;
    logic [31:0] inst;
    logic        ICACHE_stall;
    logic        ICACHE_ren;
    logic        ICACHE_wen;
    logic [29:0] ICACHE_addr;
    logic [31:0] ICACHE_rdata;
    logic [31:0] ICACHE_wdata;

    modport master (
        input  pc, invalidate, ICACHE_stall, ICACHE_rdata,
        output ready, compressed, inst,
        output ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
    );

    modport slave (
        output pc, invalidate, ICACHE_stall, ICACHE_rdata,
        input  ready, compressed, inst,
        input  ICACHE_ren, ICACHE_wen, ICACHE_addr, ICACHE_wdata
    );

endinterface

// File: rtl/fetch_line_buf.sv
// One-word line buffer holding the last completed cache word, with hit
// compares for the current word and the following word.
module fetch_line_buf
    import fetch_realign_buffer_pkg::*;
#(
    parameter logic [29:0] RESET_PC_WORD = 30'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        invalidate,
    input  logic        upd_en,
    input  logic [29:0] upd_addr,
    input  logic [31:0] upd_data,
    input  logic [29:0] addr_a,
    input  logic [29:0] addr_b,
    output logic        hit_a,
    output logic        hit_b,
    output logic        hi_full,
    output logic [31:0] line_data
);

    logic        line_vld;
    logic [29:0] line_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_vld  <= 1'b0;
            line_addr <= RESET_PC_WORD;
            // NOTE: a single data word is cheap to reset and keeps outputs
            // deterministic; a real storage array would be left unreset.
            line_data <= '0;
        end else if (invalidate) begin
            line_vld <= 1'b0;
        end else if (upd_en) begin
            line_vld  <= 1'b1;
            line_addr <= upd_addr;
            line_data <= upd_data;
        end
    end

    assign hit_a   = line_vld && (line_addr == addr_a);
    assign hit_b   = line_vld && (line_addr == addr_b);
    assign hi_full = is_full_width(line_data[31:16]);

endmodule

// File: rtl/fetch_realign_buffer.sv
// Realigns a halfword-aligned PC into a complete RV32IC instruction using
// one-word cache reads and a line buffer for words straddling a boundary.
module fetch_realign_buffer
    import fetch_realign_buffer_pkg::*;
#(
    parameter bit          BYTE_SWAP     = 1'b1,
    parameter logic [29:0] RESET_PC_WORD = 30'h0
) (
    input logic                   clk,
    input logic                   rst_n,
    fetch_realign_buffer_if.master bus
);

    req_state_e  state;
    logic [29:0] req_addr;
    logic        req_pend;

    logic [29:0] word_a;
    logic [29:0] word_b;
    logic        hit_a;
    logic        hit_b;
    logic        hi_full;
    logic [31:0] line_data;

    logic        sel_b;
    logic [29:0] target;
    logic        hit_tgt;
    logic        ren;
    logic [29:0] rd_addr;
    logic        done;
    logic        fresh;
    logic [31:0] cw;
    logic        avail_a;
    logic        avail_b;
    logic [31:0] w_a;
    logic [31:0] w_b;

    logic        ready_c;
    logic        compressed_c;
    logic [31:0] inst_c;

    logic        unused_pc0;
    assign unused_pc0 = bus.pc[0];

    assign word_a = bus.pc[31:2];
    assign word_b = word_a + 30'd1;

    fetch_line_buf #(
        .RESET_PC_WORD(RESET_PC_WORD)
    ) u_line_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .invalidate (bus.invalidate),
        .upd_en     (done),
        .upd_addr   (rd_addr),
        .upd_data   (cw),
        .addr_a     (word_a),
        .addr_b     (word_b),
        .hit_a      (hit_a),
        .hit_b      (hit_b),
        .hi_full    (hi_full),
        .line_data  (line_data)
    );

    // Fetch the next word only once the line already holds the first half
    // of a straddling instruction.
    assign sel_b   = bus.pc[1] && hit_a && hi_full;
    assign target  = sel_b ? word_b : word_a;
    assign hit_tgt = sel_b ? hit_b : hit_a;

    assign req_pend = (state == REQ_PEND);
    assign ren      = rst_n && (req_pend || !hit_tgt);
    assign rd_addr  = req_pend ? req_addr : target;
    assign done     = ren && !bus.ICACHE_stall;
    assign cw       = BYTE_SWAP ? byte_swap(bus.ICACHE_rdata) : bus.ICACHE_rdata;

    // A stale request from before a PC change completes into the line but
    // never feeds the output directly.
    assign fresh   = done && (!req_pend || (req_addr == target));
    assign avail_a = hit_a || (fresh && (rd_addr == word_a));
    assign avail_b = hit_b || (fresh && (rd_addr == word_b));
    assign w_a     = hit_a ? line_data : cw;
    assign w_b     = hit_b ? line_data : cw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ_IDLE;
            req_addr <= '0;
        end else begin
            case (state)
                REQ_IDLE: begin
                    if (ren && bus.ICACHE_stall) begin
                        state    <= REQ_PEND;
                        req_addr <= rd_addr;
                    end
                end
                REQ_PEND: begin
                    if (!bus.ICACHE_stall) begin
                        state <= REQ_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the branches infers a latch.
        ready_c      = 1'b0;
        compressed_c = 1'b0;
        inst_c       = NOP;
        if (!bus.pc[1]) begin
            ready_c = avail_a;
            if (is_full_width(w_a[15:0])) begin
                inst_c = w_a;
            end else begin
                compressed_c = 1'b1;
                inst_c       = {16'h0, w_a[15:0]};
            end
        end else if (!is_full_width(w_a[31:16])) begin
            ready_c      = avail_a;
            compressed_c = 1'b1;
            inst_c       = {16'h0, w_a[31:16]};
        end else begin
            ready_c = hit_a && avail_b;
            inst_c  = {w_b[15:0], w_a[31:16]};
        end
    end

    assign bus.ready        = rst_n && ready_c;
    assign bus.compressed   = compressed_c;
    assign bus.inst         = inst_c;
    assign bus.ICACHE_ren   = ren;
    assign bus.ICACHE_addr  = rd_addr;
    assign bus.ICACHE_wen   = 1'b0;
    assign bus.ICACHE_wdata = '0;

endmodule

// File: tb/tb_fetch_realign_buffer.sv
// Self-checking bench for fetch_realign_buffer: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_fetch_realign_buffer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:1023];

    fetch_realign_buffer_if bus ();

    fetch_realign_buffer #(
        .BYTE_SWAP     (1'b1),
        .RESET_PC_WORD (30'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Cache returns memory byte 0 in the top byte.
    assign bus.ICACHE_rdata = swap32(mem[bus.ICACHE_addr[9:0]]);

    function automatic logic [15:0] half_at(input logic [31:0] addr);
        logic [31:0] w;
        w = mem[addr[11:2]];
        return addr[1] ? w[31:16] : w[15:0];
    endfunction

    task automatic drive(input logic [31:0] pc, input logic stall, input logic inv);
        @(negedge clk);
        bus.pc           = pc;
        bus.ICACHE_stall = stall;
        bus.invalidate   = inv;
        #1;
    endtask

    task automatic test_reset;
        mem[10'h040] = 32'h00500093;
        rst_n = 1'b0;
        bus.pc = 32'h100; bus.ICACHE_stall = 1'b0; bus.invalidate = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.ICACHE_ren, bus.ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle got ren=%0b ready=%0b want 0/0", bus.ICACHE_ren, bus.ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'h40, 1'b1}) begin
            errors++;
            $display("FAIL aligned_req got ren=%0b addr=%h ready=%0b want 1/40/1",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
        end
        checks++;
        if ({bus.compressed, bus.inst} !== {1'b0, 32'h00500093}) begin
            errors++;
            $display("FAIL aligned_inst got c=%0b inst=%h want 0/00500093", bus.compressed, bus.inst);
        end
    endtask

    task automatic test_rvc_pair;
        mem[10'h080] = 32'h45054585;
        drive(32'h200, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'h80, 1'b1}) begin
            errors++;
            $display("FAIL rvc_first_req got ren=%0b addr=%h ready=%0b want 1/80/1",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
        end
        checks++;
        if ({bus.compressed, bus.inst} !== {1'b1, 32'h00004585}) begin
            errors++;
            $display("FAIL rvc_first_inst got c=%0b inst=%h want 1/00004585", bus.compressed, bus.inst);
        end
        drive(32'h202, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ready, bus.compressed, bus.inst} !== {1'b0, 1'b1, 1'b1, 32'h00004505}) begin
            errors++;
            $display("FAIL rvc_second got ren=%0b ready=%0b c=%0b inst=%h want 0/1/1/00004505",
                     bus.ICACHE_ren, bus.ready, bus.compressed, bus.inst);
        end
    endtask

    task automatic test_straddle;
        mem[10'h0C0] = 32'h00930001;
        mem[10'h0C1] = 32'h45010050;
        drive(32'h302, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'hC0, 1'b0}) begin
            errors++;
            $display("FAIL straddle_c0 got ren=%0b addr=%h ready=%0b want 1/c0/0",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
        end
        drive(32'h302, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'hC1, 1'b1}) begin
            errors++;
            $display("FAIL straddle_c1 got ren=%0b addr=%h ready=%0b want 1/c1/1",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
        end
        checks++;
        if ({bus.compressed, bus.inst} !== {1'b0, 32'h00500093}) begin
            errors++;
            $display("FAIL straddle_inst got c=%0b inst=%h want 0/00500093", bus.compressed, bus.inst);
        end
        drive(32'h306, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ready, bus.compressed, bus.inst} !== {1'b0, 1'b1, 1'b1, 32'h00004501}) begin
            errors++;
            $display("FAIL straddle_next got ren=%0b ready=%0b c=%0b inst=%h want 0/1/1/00004501",
                     bus.ICACHE_ren, bus.ready, bus.compressed, bus.inst);
        end
    endtask

    task automatic test_stall_redirect;
        logic [31:0] pcs [4];
        pcs = '{32'h100, 32'h800, 32'h800, 32'h800};
        mem[10'h200] = 32'h00A00113;
        for (int i = 0; i < 4; i++) begin
            drive(pcs[i], (i < 3), 1'b0);
            checks++;
            if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'h40, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold_%0d got ren=%0b addr=%h ready=%0b want 1/40/0",
                         i, bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
            end
        end
        drive(32'h800, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready, bus.compressed, bus.inst}
                !== {1'b1, 30'h200, 1'b1, 1'b0, 32'h00A00113}) begin
            errors++;
            $display("FAIL redirect_fetch got ren=%0b addr=%h ready=%0b c=%0b inst=%h want 1/200/1/0/00a00113",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready, bus.compressed, bus.inst);
        end
    endtask

    task automatic test_invalidate;
        drive(32'h100, 1'b0, 1'b0);
        drive(32'h100, 1'b0, 1'b1);
        checks++;
        if ({bus.ICACHE_ren, bus.ready} !== 2'b01) begin
            errors++;
            $display("FAIL inval_hit got ren=%0b ready=%0b want 0/1", bus.ICACHE_ren, bus.ready);
        end
        drive(32'h100, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr} !== {1'b1, 30'h40}) begin
            errors++;
            $display("FAIL inval_refetch got ren=%0b addr=%h want 1/40", bus.ICACHE_ren, bus.ICACHE_addr);
        end
        drive(32'h800, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ICACHE_ren, bus.ready} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_stall got ren=%0b ready=%0b want 0/0", bus.ICACHE_ren, bus.ready);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.pc = 32'h100; bus.ICACHE_stall = 1'b0;
        #1;
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'h40, 1'b1}) begin
            errors++;
            $display("FAIL pend_cleared got ren=%0b addr=%h ready=%0b want 1/40/1",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
        end
    endtask

    task automatic test_wrap;
        mem[10'h3FF] = 32'h05130001;
        mem[10'h000] = 32'h12340000;
        drive(32'hFFFF_FFFE, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {1'b1, 30'h3FFFFFFF, 1'b0}) begin
            errors++;
            $display("FAIL wrap_first got ren=%0b addr=%h ready=%0b want 1/3fffffff/0",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready);
        end
        drive(32'hFFFF_FFFE, 1'b0, 1'b0);
        checks++;
        if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready, bus.compressed, bus.inst}
                !== {1'b1, 30'h0, 1'b1, 1'b0, 32'h00000513}) begin
            errors++;
            $display("FAIL wrap_second got ren=%0b addr=%h ready=%0b c=%0b inst=%h want 1/0/1/0/00000513",
                     bus.ICACHE_ren, bus.ICACHE_addr, bus.ready, bus.compressed, bus.inst);
        end
    endtask

    // Reference: the model knows which word the buffer last completed and
    // any outstanding request; instructions are decoded straight from memory.
    task automatic test_random;
        logic        m_vld, m_pend;
        logic [29:0] m_addr, m_req;
        logic [31:0] pc;
        logic        stall, inv, prev_ready;
        logic [29:0] a, b, tgt, e_addr;
        logic [15:0] h0;
        logic        full, straddle, hit_a, hit_b, e_ren, done, fresh, e_ready;
        logic [31:0] e_inst;

        for (int i = 0; i < 1024; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (r[0]) r[17:16] = 2'b11;
            if (r[1]) r[1:0]   = 2'b11;
            mem[i] = r;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_vld = 1'b0; m_pend = 1'b0; m_addr = '0; m_req = '0;
        prev_ready = 1'b1;
        pc = 32'h0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (prev_ready || ($urandom_range(0, 3) == 0)) begin
                a  = 30'($urandom_range(0, 23)) - 30'd8;
                pc = {a, $urandom_range(0, 1) == 1, 1'b0};
            end
            stall = ($urandom_range(0, 9) < 3);
            inv   = ($urandom_range(0, 19) == 0);
            drive(pc, stall, inv);

            a        = pc[31:2];
            b        = a + 30'd1;
            h0       = half_at(pc);
            full     = (h0[1:0] == 2'b11);
            straddle = pc[1] && full;
            hit_a    = m_vld && (m_addr == a);
            hit_b    = m_vld && (m_addr == b);
            tgt      = (straddle && hit_a) ? b : a;
            e_ren    = m_pend || !(m_vld && (m_addr == tgt));
            e_addr   = m_pend ? m_req : tgt;
            done     = e_ren && !stall;
            fresh    = done && (!m_pend || (m_req == tgt));
            e_ready  = straddle ? (hit_a && (hit_b || (fresh && e_addr == b)))
                                : (hit_a || (fresh && e_addr == a));
            e_inst   = full ? {half_at(pc + 32'd2), h0} : {16'h0, h0};

            checks++;
            if ({bus.ICACHE_ren, bus.ICACHE_addr, bus.ready} !== {e_ren, e_addr, e_ready}) begin
                errors++;
                $display("FAIL rand_ctrl cyc=%0d pc=%h got ren=%0b addr=%h ready=%0b want %0b/%h/%0b",
                         cyc, pc, bus.ICACHE_ren, bus.ICACHE_addr, bus.ready, e_ren, e_addr, e_ready);
            end
            if (e_ready) begin
                checks++;
                if ({bus.compressed, bus.inst} !== {!full, e_inst}) begin
                    errors++;
                    $display("FAIL rand_inst cyc=%0d pc=%h got c=%0b inst=%h want %0b/%h",
                             cyc, pc, bus.compressed, bus.inst, !full, e_inst);
                end
            end
            checks++;
            if ({bus.ICACHE_wen, bus.ICACHE_wdata} !== 33'h0) begin
                errors++;
                $display("FAIL tie_off cyc=%0d got wen=%0b wdata=%h want 0/0",
                         cyc, bus.ICACHE_wen, bus.ICACHE_wdata);
            end

            if (e_ren && stall && !m_pend) begin
                m_pend = 1'b1;
                m_req  = e_addr;
            end else if (done) begin
                m_pend = 1'b0;
            end
            if (inv) begin
                m_vld = 1'b0;
            end else if (done) begin
                m_vld  = 1'b1;
                m_addr = e_addr;
            end
            prev_ready = e_ready;
        end
    endtask

    initial begin
        test_reset;
        test_rvc_pair;
        test_straddle;
        test_stall_redirect;
        test_invalidate;
        test_wrap;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_realign_buffer.md
Name: fetch_realign_buffer

Overview:
- Sits between the IF stage PC register and the instruction cache.
- Converts a 2-byte-aligned PC into a complete RV32IC instruction.
- Fetches one 32-bit cache word per request and keeps the last completed word in a line buffer, so a 32-bit instruction straddling two words is assembled over two cache reads.
- Drives IF with inst/compressed/ready; IF holds its PC while ready is low.

Parameters:
BYTE_SWAP, 1, 1: cache returns memory byte 0 in rdata[31:24], so bytes are reversed before use; 0: rdata is already little-endian packed.
RESET_PC_WORD, 30'h0, line_addr value loaded at reset. line_vld is also cleared at reset, so this value is never matched.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc  in  32  IF PC; bit 0 is ignored
invalidate  in  1  clears the line buffer (fence.i / redirect hygiene)
ready  out  1  inst/compressed are valid for pc this cycle
compressed  out  1  inst is a 16-bit RVC encoding
inst  out  32  instruction; for RVC, {16'h0, halfword}
ICACHE_stall  in  1  cache busy; the current request has not completed
ICACHE_ren  out  1  read request
ICACHE_wen  out  1  tied 0
ICACHE_addr  out  30  word address
ICACHE_rdata  in  32  read data, valid in a cycle with ren=1 and stall=0
ICACHE_wdata  out  32  tied 0

Behaviour:
- Registered state:
  - line_vld, line_addr[29:0], line_data[31:0], holding the last completed word after byte normalisation.
  - req_pend, req_addr[29:0], holding an outstanding stalled request.
- Reset (async): line_vld=0, req_pend=0, line_addr=RESET_PC_WORD, line_data=0. All outputs are then combinational, giving ren=1 (addr=pc[31:2]) whenever rst_n=1. While rst_n=0: ready=0 and ren=0.
- Definitions:
  - A = pc[31:2]; B = A+1, which wraps 30'h3FFFFFFF to 0.
  - hitA = line_vld && line_addr==A; hitB likewise for B.
  - done = ICACHE_ren && !ICACHE_stall. cw = normalised rdata.
- Target word selection:
  - Default target is A.
  - Exception: pc[1]=1, hitA, and line_data[17:16]==2'b11 (the upper half starts a 32-bit instruction). Then the target is B.
- Request:
  - If req_pend: ren=1 and addr=req_addr. The address stays stable until done, even if pc changes.
  - Else: ren=!(hit on target) and addr=target.
  - On ren && ICACHE_stall: req_pend<=1, req_addr<=addr.
  - On done: req_pend<=0.
- Line update: on done, line_addr<=addr, line_data<=cw, line_vld<=1.
- Output source word W for word X: line_data if the line hits X; else cw if done && addr==X && !req_pend-mismatch (a completing request for a different, stale address never supplies data).
- pc[1]=0:
  - ready = W(A) available; lo = W(A)[15:0].
  - If lo[1:0]!=2'b11: compressed=1, inst={16'h0,lo}.
  - Else: compressed=0, inst=W(A).
- pc[1]=1:
  - hi = W(A)[31:16].
  - If hi[1:0]!=2'b11: ready = W(A) available, compressed=1.
  - Else: ready = hitA && W(B) available, inst={W(B)[15:0], hi}, compressed=0.
- When ready=0: inst and compressed are don't-care; the bench must not check them.
- Latency with a zero-stall cache: aligned word or RVC hit is 0 cycles; line miss is 1 completing read in the same cycle; straddle with line miss on A is 2 cycles (read A, then read B).
- A straddle consumes B into the line, so a following instruction in B hits.
- invalidate: line_vld<=0 next edge. It has priority over a same-cycle line update. A pending request still completes, but its data is discarded from the line.
- Simultaneous pc change and stalled request: the old request finishes and updates the line, then the new target is issued.
- ICACHE_wen=0 and ICACHE_wdata=0 always.

Decomposition:
- Shared package: localparam NOP=32'h00000013, RVC_MASK check (2'b11 = 32-bit), and a byte-swap function used here and by the data path.
- A natural sub-module is fetch_line_buf, holding the line registers and hit compare. The top level holds the request FSM (IDLE/PEND) and output assembly.

Test Plan:
- Aligned 32-bit: pc=0x100, mem word 0x00500093, zero-stall -> cycle 0: ren=1, addr=0x40, ready=1, compressed=0, inst=0x00500093.
- Two RVC in one word: pc=0x200 then 0x202, word = {0x4505,0x4585} (hi,lo) -> first: inst=0x00004585, compressed=1, 1 read; second: ready with ren=0 (line hit).
- Straddle: pc=0x302, word 0xC0 hi=0x0093, word 0xC1 lo=0x0050 -> cycle 0 reads 0xC0, ready=0; cycle 1 reads 0xC1, ready=1, inst=0x00500093; pc=0x306 next hits the line.
- Stall plus redirect: ICACHE_stall=1 for 3 cycles on addr 0x40 while pc jumps to 0x800 -> addr stays 0x40 until done, then addr=0x200; ready only for 0x800 data.
- Invalidate and reset: line holds 0x40, pulse invalidate, pc=0x100 -> ren=1 again. Assert rst_n=0 mid-stall -> ready=0 and req_pend=0 immediately.
- Wrap: pc=0xFFFFFFFE with hi=0x..11 -> second read addr=30'h0.
